// File: rtl/i2s_pkg.sv
// Shared widths and channel encoding for the I2S master.
// Optional feature macro: I2S_LOOPBACK_EN (see i2s_master_rx_tx.sv).
package i2s_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int SCK_DIV    = 8;
    localparam int DIV_W      = $clog2(SCK_DIV);
    localparam int BIT_W      = $clog2(DATA_WIDTH) + 1;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } channel_e;
endpackage

// File: rtl/basic_i2s_receive.sv
// I2S deserialiser: shifts sd_in MSB first on SCK rises and latches the word
// of the previous channel when ws flips (standard one-bit delay).
module basic_i2s_receive
    import i2s_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_rise,
    input  logic                  i_ws,
    input  logic                  i_sd,
    output logic [DATA_WIDTH-1:0] o_left,
    output logic [DATA_WIDTH-1:0] o_right
);
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_right;
    channel_e              r_ws_prev;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_word = {r_shift[DATA_WIDTH-2:0], i_sd};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift   <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_ws_prev <= LEFT;
        end else if (i_rise) begin
            r_shift   <= w_word;
            r_ws_prev <= channel_e'(i_ws);
            // The bit sampled with the new ws is the old channel's LSB
            if (channel_e'(i_ws) != r_ws_prev) begin
                if (r_ws_prev == LEFT) r_left  <= w_word;
                else                   r_right <= w_word;
            end
        end
    end

    assign o_left  = r_left;
    assign o_right = r_right;
endmodule

// File: rtl/basic_i2s_transmit.sv
// I2S serialiser: drives the shift MSB on each SCK fall; on a ws change the
// old LSB still goes out while the new channel word is loaded.
module basic_i2s_transmit
    import i2s_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_fall,
    input  logic                  i_ws_chg,
    input  logic                  i_ws,
    input  logic [DATA_WIDTH-1:0] i_left,
    input  logic [DATA_WIDTH-1:0] i_right,
    output logic                  o_sd
);
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_sd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift <= '0;
            r_sd    <= 1'b0;
        end else if (i_fall) begin
            r_sd <= r_shift[DATA_WIDTH-1];
            if (i_ws_chg)
                r_shift <= (channel_e'(i_ws) == RIGHT) ? i_right : i_left;
            else
                r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign o_sd = r_sd;
endmodule

// File: rtl/i2s_controller.sv
// Clock generator: free-running divider gives SCK, a bit counter clocked on
// SCK falling edges gives WS.
module i2s_controller
    import i2s_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    output logic o_sck,
    output logic o_ws
);
    logic [DIV_W-1:0] r_div_cnt;
    logic [BIT_W-1:0] r_bit_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            // div_cnt wrapping to 0 is the SCK falling edge
            if (r_div_cnt == DIV_W'(SCK_DIV - 1))
                r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign o_sck = r_div_cnt[DIV_W-1];
    assign o_ws  = r_bit_cnt[BIT_W-1];
endmodule

// File: rtl/i2s_edge_detect.sv
// Registers sck/ws and emits one-clk strobes for SCK rise, SCK fall and a
// ws change; o_ws is ws aligned with those strobes.
module i2s_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic i_sck,
    input  logic i_ws,
    output logic o_rise,
    output logic o_fall,
    output logic o_ws_chg,
    output logic o_ws
);
    logic r_sck_q;
    logic r_ws_q;
    logic r_rise;
    logic r_fall;
    logic r_ws_chg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sck_q  <= 1'b0;
            r_ws_q   <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_ws_chg <= 1'b0;
        end else begin
            r_sck_q  <= i_sck;
            r_ws_q   <= i_ws;
            r_rise   <= i_sck & ~r_sck_q;
            r_fall   <= ~i_sck & r_sck_q;
            r_ws_chg <= i_ws ^ r_ws_q;
        end
    end

    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_ws_chg = r_ws_chg;
    assign o_ws     = r_ws_q;
endmodule

// File: rtl/i2s_master_rx_tx.sv
// 32-bit stereo I2S master (rx + tx), structural top.
// Define I2S_LOOPBACK_EN to retransmit received words instead of tx_left/tx_right.
module i2s_master_rx_tx
    import i2s_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  mclk,
    output logic                  sck,
    output logic                  ws,
    input  logic                  sd_in,
    output logic                  sd_out,
    output logic [DATA_WIDTH-1:0] rx_left,
    output logic [DATA_WIDTH-1:0] rx_right,
    input  logic [DATA_WIDTH-1:0] tx_left,
    input  logic [DATA_WIDTH-1:0] tx_right
);
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_ws_chg;
    logic                  w_ws_q;
    logic [DATA_WIDTH-1:0] w_tx_left;
    logic [DATA_WIDTH-1:0] w_tx_right;

    assign mclk = clk;

`ifdef I2S_LOOPBACK_EN
    logic w_unused_tx;
    assign w_unused_tx = ^{tx_left, tx_right};
    assign w_tx_left   = rx_left;
    assign w_tx_right  = rx_right;
`else
    assign w_tx_left   = tx_left;
    assign w_tx_right  = tx_right;
`endif

    i2s_controller u_ctrl (
        .clk    (clk),
        .resetn (resetn),
        .o_sck  (sck),
        .o_ws   (ws)
    );

    i2s_edge_detect u_edge (
        .clk      (clk),
        .resetn   (resetn),
        .i_sck    (sck),
        .i_ws     (ws),
        .o_rise   (w_rise),
        .o_fall   (w_fall),
        .o_ws_chg (w_ws_chg),
        .o_ws     (w_ws_q)
    );

    basic_i2s_receive u_rx (
        .clk     (clk),
        .resetn  (resetn),
        .i_rise  (w_rise),
        .i_ws    (w_ws_q),
        .i_sd    (sd_in),
        .o_left  (rx_left),
        .o_right (rx_right)
    );

    basic_i2s_transmit u_tx (
        .clk      (clk),
        .resetn   (resetn),
        .i_fall   (w_fall),
        .i_ws_chg (w_ws_chg),
        .i_ws     (w_ws_q),
        .i_left   (w_tx_left),
        .i_right  (w_tx_right),
        .o_sd     (sd_out)
    );
endmodule

// File: tb/tb_i2s_master_rx_tx.sv
// Bench for i2s_master_rx_tx: cycle-indexed protocol model of SCK/WS, the
// incoming bit stream and the expected sd_out stream.
module tb_i2s_master_rx_tx;
    import i2s_pkg::*;

    localparam int DW   = DATA_WIDTH;
    localparam int SLOT = DATA_WIDTH * SCK_DIV;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sd_in = 1'b0;
    logic          mclk, sck, ws, sd_out;
    logic [DW-1:0] rx_left, rx_right;
    logic [DW-1:0] tx_left, tx_right;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] w_words [0:15];
    logic [DW-1:0] t_words [0:15];
    logic [DW-1:0] exp_q [$];

    // clock/reset block
    always #10 clk = ~clk;

    i2s_master_rx_tx dut (
        .clk      (clk),
        .resetn   (resetn),
        .mclk     (mclk),
        .sck      (sck),
        .ws       (ws),
        .sd_in    (sd_in),
        .sd_out   (sd_out),
        .rx_left  (rx_left),
        .rx_right (rx_right),
        .tx_left  (tx_left),
        .tx_right (tx_right)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Latest word of channel ch among slots 0..kmax
    function automatic logic [DW-1:0] last_word(input int ch, input int kmax);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k <= kmax; k++)
            if (k % 2 == ch) r = w_words[k];
        return r;
    endfunction

    // I2S bit on the wire in SCK period p: period 0 of a slot carries the
    // previous word's LSB, periods 1..31 carry the slot's word MSB first.
    function automatic logic wire_bit(input int p, input logic is_tx);
        int h;
        int j;
        h = p / DW;
        j = p % DW;
        if (j == 0) begin
            if (h == 0) return 1'b0;
            return is_tx ? t_words[h-1][0] : w_words[h-1][0];
        end
        return is_tx ? t_words[h][DW-j] : w_words[h][DW-j];
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_sck"}, DW'(sck), '0);
        check({tag, "_ws"}, DW'(ws), '0);
        check({tag, "_sd_out"}, DW'(sd_out), '0);
        check({tag, "_rx_left"}, rx_left, '0);
        check({tag, "_rx_right"}, rx_right, '0);
    endtask

    // Runs ncycles clk cycles from reset release; each iteration is at the
    // negedge after n posedges.
    task automatic run_phase(input int ncycles, input int rand_from_slot);
        int p, h, m, kmax;
        logic [DW-1:0] e;
        for (int n = 0; n < ncycles; n++) begin
            p = n / SCK_DIV;
            h = n / SLOT;
            m = n % SLOT;
            check("sck", DW'(sck), DW'((n % SCK_DIV) >= SCK_DIV / 2));
            check("ws", DW'(ws), DW'(h % 2));
            if (m == 0 && h >= 1) begin
`ifdef I2S_LOOPBACK_EN
                t_words[h] = (h >= 2) ? w_words[h-2] : '0;
`else
                t_words[h] = (h % 2 == 1) ? tx_right : tx_left;
`endif
            end
            if (n % SCK_DIV == 0) sd_in = wire_bit(p, 1'b0);
            if (n % SCK_DIV == SCK_DIV / 2) check("sd_out", DW'(sd_out), DW'(wire_bit(p, 1'b1)));
            if (m == 5 || m == SLOT / 2) begin
                kmax = (m >= 6) ? h - 1 : h - 2;
                check("rx_left", rx_left, last_word(0, kmax));
                check("rx_right", rx_right, last_word(1, kmax));
            end
            if (m == 6 && h >= 1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rx_word", ((h - 1) % 2 == 1) ? rx_right : rx_left, e);
                end else begin
                    check("rx_sb_empty", DW'(exp_q.size()), DW'(1));
                end
            end
            if (m == SLOT / 2 && h >= rand_from_slot) begin
                tx_left  = $urandom;
                tx_right = $urandom;
            end
            if (n % 64 == 0) check("mclk_lo", DW'(mclk), '0);
            @(posedge clk);
            if (n % SCK_DIV == 0) begin
                #1;
                check("mclk_hi", DW'(mclk), DW'(1));
            end
            @(negedge clk);
        end
    endtask

    task automatic load_words(input logic directed);
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            w_words[k] = $urandom;
            t_words[k] = '0;
        end
        if (directed) begin
            for (int k = 0; k < 4; k++) w_words[k] = 32'hAAAA_AAAA;
            w_words[4] = 32'h8000_0001;
            w_words[5] = 32'h1234_5678;
        end
        for (int k = 0; k < 16; k++) exp_q.push_back(w_words[k]);
    endtask

    initial begin
        tx_left  = 32'hDEAD_BEEF;
        tx_right = 32'h0000_0001;
        resetn   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #1;
        check("mclk_in_reset", DW'(mclk), DW'(1));
        @(negedge clk);

        // Phase 1: directed words, fixed tx words for the first slots,
        // then reset asserted in the middle of a bit of slot 6.
        load_words(1'b1);
        resetn = 1'b1;
        run_phase(6 * SLOT + 13 * SCK_DIV + 3, 4);
        resetn = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(posedge clk);
        #1;
        check("mclk_mid_rst", DW'(mclk), DW'(1));
        @(negedge clk);

        // Phase 2: random words after the mid-frame reset
        load_words(1'b0);
        resetn = 1'b1;
        run_phase(6 * SLOT + 16, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
